// File: rtl/wb_pwm_mc_pkg.sv
// Shared constants for the wb_pwm_mc PWM peripheral: register byte addresses
// and CTRL bit positions.
package wb_pwm_mc_pkg;

  localparam logic [7:0] ADR_CTRL      = 8'h00;
  localparam logic [7:0] ADR_PERIOD    = 8'h04;
  localparam logic [7:0] ADR_PSC       = 8'h08;
  localparam logic [7:0] ADR_DT        = 8'h0C;
  localparam logic [7:0] ADR_DUTY_BASE = 8'h10;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_FORCE_UPDATE = 1;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary output stage for one PWM channel: registers raw into hi/lo
// and blanks both sides for dt clocks after every raw edge.
module pwm_deadtime
  import wb_pwm_mc_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw,
  input  logic [DT_W-1:0] dt,
  input  logic            enable,
  output logic            hi,
  output logic            lo
);

  logic            raw_q;
  logic [DT_W-1:0] dt_cnt;

  // dt_cnt holds the blank cycles still owed after the current one, so a
  // dead-time of dt yields exactly dt clocks with both sides low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q  <= 1'b0;
      dt_cnt <= '0;
      hi     <= 1'b0;
      lo     <= 1'b0;
    end else begin
      raw_q <= raw;
      if (!enable) begin
        hi     <= 1'b0;
        lo     <= 1'b0;
        dt_cnt <= '0;
      end else if (raw != raw_q) begin
        if (dt == '0) begin
          hi     <= raw;
          lo     <= ~raw;
          dt_cnt <= '0;
        end else begin
          hi     <= 1'b0;
          lo     <= 1'b0;
          dt_cnt <= dt - 1'b1;
        end
      end else if (dt_cnt != '0) begin
        hi     <= 1'b0;
        lo     <= 1'b0;
        dt_cnt <= dt_cnt - 1'b1;
      end else begin
        hi <= raw;
        lo <= ~raw;
      end
    end
  end

endmodule

// File: rtl/wb_pwm_mc.sv
// Multi-channel Wishbone PWM generator: one shared prescaled counter, per-channel
// compare and dead-time, double-buffered PERIOD/DUTY/DT loaded at period wrap.
module wb_pwm_mc
  import wb_pwm_mc_pkg::*;
#(
  parameter int RES      = 16,
  parameter int CHANNELS = 4,
  parameter int PSC_W    = 16,
  parameter int DT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] pwm_n_out,
  output logic                period_tick
);

  // Handshake: an access starts when stb&cyc are high and no ack is pending;
  // that edge commits the write / captures read data and sets ack_q, the next
  // edge clears it, so each access gets exactly one wait state and one ack.
  logic       ack_q;
  logic       access;
  logic       wr;
  logic [7:0] adr;
  logic [31:0] rd_data;

  logic                en, force_q;
  logic [RES-1:0]      period, period_sh, cnt;
  logic [PSC_W-1:0]    psc, psc_cnt;
  logic [DT_W-1:0]     dt, dt_sh;
  logic [RES-1:0]      duty    [CHANNELS];
  logic [RES-1:0]      duty_sh [CHANNELS];
  logic [CHANNELS-1:0] raw;

  logic en_nxt, en_rise, tick, wrap, load_sh, dt_en;
  logic unused_bits;

  assign adr         = wb_adr_i[7:0];
  assign access      = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr          = access & wb_we_i;
  assign wb_ack_o    = wb_stb_i & wb_cyc_i & ack_q;
  assign unused_bits = ^{wb_sel_i, wb_adr_i, wb_dat_i};

  always_comb begin
    rd_data = '0;
    if (adr == ADR_CTRL)        rd_data[CTRL_EN]   = en;
    else if (adr == ADR_PERIOD) rd_data[RES-1:0]   = period;
    else if (adr == ADR_PSC)    rd_data[PSC_W-1:0] = psc;
    else if (adr == ADR_DT)     rd_data[DT_W-1:0]  = dt;
    for (int i = 0; i < CHANNELS; i++)
      if (adr == ADR_DUTY_BASE + 8'(4 * i)) rd_data[RES-1:0] = duty[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      wb_dat_o <= '0;
      en       <= 1'b0;
      force_q  <= 1'b0;
      period   <= '1;
      psc      <= '0;
      dt       <= '0;
      for (int i = 0; i < CHANNELS; i++) duty[i] <= '0;
    end else begin
      ack_q   <= access;
      force_q <= wr && (adr == ADR_CTRL) && wb_dat_i[CTRL_FORCE_UPDATE];
      if (access && !wb_we_i) wb_dat_o <= rd_data;
      if (wr) begin
        if (adr == ADR_CTRL)   en     <= wb_dat_i[CTRL_EN];
        if (adr == ADR_PERIOD) period <= wb_dat_i[RES-1:0];
        if (adr == ADR_PSC)    psc    <= wb_dat_i[PSC_W-1:0];
        if (adr == ADR_DT)     dt     <= wb_dat_i[DT_W-1:0];
        for (int i = 0; i < CHANNELS; i++)
          if (adr == ADR_DUTY_BASE + 8'(4 * i)) duty[i] <= wb_dat_i[RES-1:0];
      end
    end
  end

  // en_nxt lets a disabling write force the safe state on its own commit edge.
  assign en_nxt      = (wr && adr == ADR_CTRL) ? wb_dat_i[CTRL_EN] : en;
  assign en_rise     = en_nxt & ~en;
  assign tick        = en && (psc_cnt >= psc);
  assign wrap        = tick && (cnt >= period_sh);
  assign load_sh     = wrap | en_rise | force_q;
  assign period_tick = wrap;
  assign dt_en       = en & en_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      psc_cnt   <= '0;
      period_sh <= '1;
      dt_sh     <= '0;
      for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= '0;
    end else begin
      if (!en_nxt || en_rise) begin
        cnt     <= '0;
        psc_cnt <= '0;
      end else if (tick) begin
        psc_cnt <= '0;
        cnt     <= wrap ? '0 : cnt + 1'b1;
      end else begin
        psc_cnt <= psc_cnt + 1'b1;
      end
      if (load_sh) begin
        period_sh <= period;
        dt_sh     <= dt;
        for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= duty[i];
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign raw[i] = cnt < duty_sh[i];
    pwm_deadtime #(.DT_W(DT_W)) u_dt (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[i]),
      .dt     (dt_sh),
      .enable (dt_en),
      .hi     (pwm_out[i]),
      .lo     (pwm_n_out[i])
    );
  end

endmodule

// File: tb/tb_wb_pwm_mc.sv
// Bench for wb_pwm_mc: bus reads, per-period output statistics and reset state
// are checked by monitors against expectation queues filled by the stimulus.
module tb_wb_pwm_mc;

  logic        clk, rst;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, period_tick;
  logic [3:0]  pwm_out, pwm_n_out;

  typedef struct packed {
    logic [15:0]      len;
    logic [3:0][15:0] hi;
    logic [3:0][15:0] lo;
    logic [3:0][15:0] z;
  } win_t;

  logic [31:0] exp_q[$];
  logic [8:0]  wexp_q[$];
  logic [41:0] rst_q[$];
  win_t        pw_q[$];

  int checks = 0;
  int errors = 0;

  wb_pwm_mc #(.RES(16), .CHANNELS(4), .PSC_W(16), .DT_W(8)) dut (
    .clk(clk), .rst(rst), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .pwm_out(pwm_out), .pwm_n_out(pwm_n_out), .period_tick(period_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int ch, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s ch%0d got %0h exp %0h", name, ch, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    int n = 0;
    @(posedge clk); #1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    do begin @(negedge clk); n++; end while (!wb_ack_o && n < 20);
    if (!wb_ack_o) begin
      checks++; errors++;
      $display("FAIL ack_timeout adr %0h got no ack exp ack", adr);
    end
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic chk = 1'b0, input logic [7:0] exp_out = 8'h00);
    wexp_q.push_back({chk, exp_out});
    wb_access(1'b1, adr, dat);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp);
    exp_q.push_back(exp);
    wb_access(1'b0, adr, 32'h0);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!period_tick && k < 100);
      if (!period_tick) begin
        checks++; errors++;
        $display("FAIL tick_timeout got none exp period_tick");
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while (pw_q.size() != 0 && k < 400) begin @(negedge clk); k++; end
    if (pw_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL win_timeout left %0d exp 0", pw_q.size());
      pw_q.delete();
    end
  endtask

  // Window of one period: ch0 as given, ch1/ch3 at duty 0, ch2 above PERIOD.
  function automatic win_t mk(input int len, input int h0, input int l0, input int z0);
    win_t w;
    w.len   = 16'(len);
    w.hi[0] = 16'(h0);  w.lo[0] = 16'(l0);  w.z[0] = 16'(z0);
    w.hi[1] = 16'd0;    w.lo[1] = 16'(len); w.z[1] = 16'd0;
    w.hi[2] = 16'(len); w.lo[2] = 16'd0;    w.z[2] = 16'd0;
    w.hi[3] = 16'd0;    w.lo[3] = 16'(len); w.z[3] = 16'd0;
    return w;
  endfunction

  task automatic push_wins(input win_t w, input int n);
    wait_ticks(1); #1;
    for (int i = 0; i < n; i++) pw_q.push_back(w);
    drain();
  endtask

  // ---------------- monitors / scoreboard ----------------
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (rst) wait_cnt = 0;
    else if (wb_stb_i && wb_cyc_i) begin
      if (wb_ack_o) begin
        cmp("ack_wait_states", 0, wait_cnt, 1);
        if (!wb_we_i) begin
          if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL read_unexpected_ack got %0h exp none", wb_dat_o);
          end else cmp("read_data", 0, wb_dat_o, exp_q.pop_front());
        end else begin
          if (wexp_q.size() == 0) begin
            checks++; errors++; $display("FAIL write_unexpected_ack got ack exp none");
          end else begin
            logic [8:0] e;
            e = wexp_q.pop_front();
            if (e[8]) cmp("outputs_after_write", 0, {pwm_n_out, pwm_out}, e[7:0]);
          end
        end
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  int w_len;
  int w_hi[4], w_lo[4], w_z[4];
  always @(negedge clk) begin
    if (rst) begin
      w_len = 0;
      for (int c = 0; c < 4; c++) begin w_hi[c] = 0; w_lo[c] = 0; w_z[c] = 0; end
    end else begin
      cmp("overlap", 0, pwm_out & pwm_n_out, 0);
      w_len++;
      for (int c = 0; c < 4; c++) begin
        w_hi[c] += int'(pwm_out[c]);
        w_lo[c] += int'(pwm_n_out[c]);
        w_z[c]  += int'(!pwm_out[c] && !pwm_n_out[c]);
      end
      if (period_tick) begin
        if (pw_q.size() != 0) begin
          win_t e;
          e = pw_q.pop_front();
          cmp("win_len", 0, w_len, e.len);
          for (int c = 0; c < 4; c++) begin
            cmp("win_hi", c, w_hi[c], e.hi[c]);
            cmp("win_lo", c, w_lo[c], e.lo[c]);
            cmp("win_both_low", c, w_z[c], e.z[c]);
          end
        end
        w_len = 0;
        for (int c = 0; c < 4; c++) begin w_hi[c] = 0; w_lo[c] = 0; w_z[c] = 0; end
      end
    end
  end

  always @(posedge rst) begin
    #1;
    if (rst_q.size() != 0)
      cmp("reset_outputs", 0, {wb_dat_o, wb_ack_o, period_tick, pwm_n_out, pwm_out},
          rst_q.pop_front());
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
    rst_q.push_back(42'h0);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // register reset values and decode
    wb_read(32'h00, 32'h0);
    wb_read(32'h04, 32'h0000FFFF);
    wb_read(32'h08, 32'h0);
    wb_read(32'h0C, 32'h0);
    for (int i = 0; i < 4; i++) wb_read(32'h10 + 32'(4 * i), 32'h0);
    wb_read(32'hFC, 32'h0);
    wb_write(32'h18, 32'h1234);
    wb_read(32'h18, 32'h00001234);
    wb_write(32'h20, 32'hDEAD);
    wb_read(32'h20, 32'h0);
    wb_write(32'h00, 32'h2);
    wb_read(32'h00, 32'h0);

    // basic PWM plus duty boundaries on ch1/ch2
    wb_write(32'h04, 32'd9);
    wb_write(32'h08, 32'd0);
    wb_write(32'h0C, 32'd0);
    wb_write(32'h10, 32'd3);
    wb_write(32'h14, 32'd0);
    wb_write(32'h18, 32'd10);
    wb_write(32'h00, 32'h1);
    wb_read(32'h04, 32'd9);
    wb_read(32'h00, 32'h1);
    push_wins(mk(10, 3, 7, 0), 2);

    // mid-period duty write holds until the wrap
    wait_ticks(1); #1;
    pw_q.push_back(mk(10, 3, 7, 0));
    pw_q.push_back(mk(10, 7, 3, 0));
    wb_write(32'h10, 32'd7);
    drain();

    // forced update lands within the same period
    wb_write(32'h10, 32'd10);
    wait_ticks(3); #1;
    pw_q.push_back(mk(10, 6, 4, 0));
    pw_q.push_back(mk(10, 0, 10, 0));
    wb_write(32'h10, 32'd0);
    wb_write(32'h00, 32'h3);
    drain();
    wb_read(32'h00, 32'h1);

    // dead-time, then a pulse narrower than the dead-time
    wb_write(32'h10, 32'd3);
    wb_write(32'h0C, 32'd2);
    wait_ticks(2);
    push_wins(mk(10, 1, 5, 4), 2);
    wb_write(32'h10, 32'd1);
    wait_ticks(2);
    push_wins(mk(10, 0, 7, 3), 2);

    // PERIOD=0: wrap every clock
    wb_write(32'h04, 32'd0);
    wb_write(32'h0C, 32'd0);
    wb_write(32'h10, 32'd1);
    wait_ticks(10);
    push_wins(mk(1, 1, 0, 0), 4);

    // prescaler of 2
    wb_write(32'h04, 32'd9);
    wb_write(32'h08, 32'd1);
    wb_write(32'h10, 32'd3);
    wait_ticks(3);
    push_wins(mk(20, 6, 14, 0), 2);

    // disable drives the safe state on the ack cycle
    wb_write(32'h00, 32'h0, 1'b1, 8'h00);
    wb_read(32'h00, 32'h0);

    // asynchronous reset in the middle of a write
    wb_write(32'h00, 32'h1);
    wait_ticks(2);
    @(posedge clk); #1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h18; wb_dat_i = 32'h5555;
    #2;
    rst_q.push_back(42'h0);
    rst = 1'b1;
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wb_read(32'h00, 32'h0);
    wb_read(32'h04, 32'h0000FFFF);
    wb_read(32'h08, 32'h0);
    wb_read(32'h0C, 32'h0);
    wb_read(32'h10, 32'h0);
    wb_read(32'h18, 32'h0);

    repeat (5) @(negedge clk);
    cmp("leftover_reads", 0, exp_q.size(), 0);
    cmp("leftover_writes", 0, wexp_q.size(), 0);
    cmp("leftover_windows", 0, pw_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
